// File: rtl/fifo_pkg.sv
// Shared FIFO-side types: arbiter state, counter width, and a reference round-robin pick.
package fifo_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int XFER_CNT_W = 16;
  localparam int MAX_REQ    = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Behavioural pick over up to MAX_REQ requesters; n is the active count.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [3:0] ptr, input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (valid[j]) begin
        r.found = 1'b1;
        r.idx   = 4'(j);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate by ptr, find lowest set bit, rotate back.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    dbl     = {valid_i, valid_i} >> ptr_i;
    rot     = dbl[N-1:0];
    found_o = |rot;
    off     = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) off = W'(k);
    sum   = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  end
endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin write-port arbiter in front of the fifo write side.
// Define FIFO_ARB_BURST_EN to lock the winner for bursts of up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant_id,
  output logic [XFER_CNT_W-1:0]         xfer_count
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]         rr_ptr_q, win_idx, last_grant_id_q, last_grant_id_d;
  logic [NUM_REQ-1:0]    pick_valid;
  logic                  pick_found, win, xfer;
  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == IW'(NUM_REQ - 1)) ? '0 : id + IW'(1);
  endfunction

`ifdef FIFO_ARB_BURST_EN
  arb_state_t state_q;
  logic [IW-1:0] owner_q;
  logic [7:0]    beats_q;

  // While locked only the owner may compete.
  assign pick_valid = (state_q == LOCK) ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
`else
  localparam int unused_max_burst = MAX_BURST;
  assign pick_valid = req_valid;
`endif

  rr_priority_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .found_o (pick_found)
  );

  // Nothing is offered while reset is held, even with requests pending.
  assign win        = pick_found & rst_n;
  assign xfer       = win & ~fifo_full;
  assign fifo_wr_en = xfer;
  assign req_ready  = xfer ? (NUM_REQ'(1) << win_idx) : '0;
  assign fifo_din   = win ? req_data[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    xfer_count_d    = xfer_count_q;
    last_grant_id_d = last_grant_id_q;
    if (xfer) begin
      last_grant_id_d = win_idx;
      if (xfer_count_q != {XFER_CNT_W{1'b1}}) xfer_count_d = xfer_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q    <= '0;
      last_grant_id_q <= '0;
    end else begin
      xfer_count_q    <= xfer_count_d;
      last_grant_id_q <= last_grant_id_d;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      beats_q  <= '0;
      rr_ptr_q <= '0;
    end else if (!fifo_full) begin
      case (state_q)
        IDLE: if (xfer) begin
          if (MAX_BURST > 1) begin
            state_q <= LOCK;
            owner_q <= win_idx;
            beats_q <= 8'd1;
          end else begin
            rr_ptr_q <= next_id(win_idx);
          end
        end
        LOCK: if (!req_valid[owner_q] || (beats_q + 8'd1 == 8'(MAX_BURST))) begin
          state_q  <= IDLE;
          beats_q  <= '0;
          rr_ptr_q <= next_id(owner_q);
        end else begin
          beats_q <= beats_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr_q <= '0;
    else if (xfer) rr_ptr_q <= next_id(win_idx);
  end
`endif

  assign last_grant_id = last_grant_id_q;
  assign xfer_count    = xfer_count_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 producers, 8-bit data, MAX_BURST=4).
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  last_grant_id;
  logic [15:0] xfer_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .last_grant_id (last_grant_id),
    .xfer_count    (xfer_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the combinational offer for this cycle, then let the edge happen.
  task automatic beat(input logic [7:0] din, input logic wr, input logic [3:0] rdy);
    #1;
    check("din", 32'(fifo_din), 32'(din));
    check("wr_en", 32'(fifo_wr_en), 32'(wr));
    check("ready", 32'(req_ready), 32'(rdy));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h13121110;
    fifo_full = 1'b0;
    #2;
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_last", 32'(last_grant_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifndef FIFO_ARB_BURST_EN
    for (int k = 0; k < 8; k++) beat(8'h10 + 8'(k % 4), 1'b1, 4'b0001 << (k % 4));
    check("rr_count", 32'(xfer_count), 32'd8);
    check("rr_last", 32'(last_grant_id), 32'd3);

    beat(8'h10, 1'b1, 4'b0001);
    beat(8'h11, 1'b1, 4'b0010);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) beat(8'h12, 1'b0, 4'b0000);
    check("full_count", 32'(xfer_count), 32'd10);
    check("full_last", 32'(last_grant_id), 32'd1);
    fifo_full = 1'b0;
    beat(8'h12, 1'b1, 4'b0100);
    check("resume_last", 32'(last_grant_id), 32'd2);

    req_valid = 4'b0010;
    beat(8'h11, 1'b1, 4'b0010);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++)
      beat((k % 2 == 0) ? 8'h13 : 8'h11, 1'b1, (k % 2 == 0) ? 4'b1000 : 4'b0010);
    check("sparse_count", 32'(xfer_count), 32'd16);
    check("sparse_last", 32'(last_grant_id), 32'd1);

    req_valid = 4'b0000;
    beat(8'h00, 1'b0, 4'b0000);
    check("idle_count", 32'(xfer_count), 32'd16);
`else
    for (int k = 0; k < 8; k++) beat(8'h10 + 8'(k / 4), 1'b1, 4'b0001 << (k / 4));
    check("burst_count", 32'(xfer_count), 32'd8);
    check("burst_last", 32'(last_grant_id), 32'd1);
    beat(8'h12, 1'b1, 4'b0100);
    beat(8'h12, 1'b1, 4'b0100);
    req_valid = 4'b1011;
    beat(8'h00, 1'b0, 4'b0000);
    beat(8'h13, 1'b1, 4'b1000);
    check("early_count", 32'(xfer_count), 32'd11);
    check("early_last", 32'(last_grant_id), 32'd3);
`endif

    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(xfer_count), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(8'h10, 1'b1, 4'b0001);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    check("sat_reach", 32'(xfer_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check("sat_hold", 32'(xfer_count), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous `fifo` among `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter selects at most one producer per cycle and drives the FIFO's `wr_en`/`din` combinationally, so the FIFO's `full` flag is honoured in the same cycle. It sits directly in front of the `fifo` instance; the FIFO read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..16)
- `DATA_WIDTH`, 8, data width, equal to the FIFO's `DATA_WIDTH`
- `MAX_BURST`, 4, maximum beats per locked burst (1..255); used only with `FIFO_ARB_BURST_EN`

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NUM_REQ  per-producer data valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  one-hot or zero; producer i's beat is accepted this cycle
- `fifo_full`  in  1  from FIFO `full`
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_din`  out  DATA_WIDTH  to FIFO `din`
- `last_grant_id`  out  $clog2(NUM_REQ)  ID of the most recently accepted producer
- `xfer_count`  out  16  saturating count of accepted beats

## Operation
- A transfer occurs on a rising edge when `req_valid[i] & req_ready[i]` for some i. At most one transfer occurs per cycle.
- Winner selection is combinational. It is the first requester with `req_valid` set, scanning upward from `rr_ptr` with wrap (NUM_REQ-1 → 0).
- `req_ready[w] = !fifo_full` for the winner w; all other bits are 0. `fifo_wr_en = valid_w & !fifo_full`. `fifo_din = req_data[w]`, or 0 when there is no winner.
- On a transfer:
  - `rr_ptr` ← (w+1) mod NUM_REQ. In burst mode this update happens only on release.
  - `last_grant_id` ← w.
  - `xfer_count` increments and saturates at 0xFFFF.
- When `fifo_full` is 1, no ready is asserted and no transfer occurs. Pointer, state, burst count and counters all hold.
- When no request is valid, all outputs are inactive and state holds.
- Reset values: `rr_ptr`=0, state IDLE, burst count 0, `last_grant_id`=0, `xfer_count`=0. With inputs low, `req_ready`, `fifo_wr_en` and `fifo_din` are all 0.
- Reset asserted mid-burst drops the lock immediately. A beat in flight that cycle is not counted.

## Timing
- Arbitration-to-write latency is 0 cycles. The FIFO captures `fifo_din` on the same edge that completes the handshake.
- Sustained throughput is 1 beat per cycle while the FIFO is not full.
- Fairness: with all producers valid and the FIFO never full, grants rotate 0,1,2,3,0,…
- `last_grant_id` and `xfer_count` update on the edge after the transfer cycle, i.e. registered.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- **Defined:** two-state FSM, IDLE and LOCK.
  - IDLE → LOCK on a transfer when MAX_BURST > 1. `owner` ← w and `beats` ← 1.
  - In LOCK, only `owner` can be granted.
  - Each owner transfer increments `beats`.
  - LOCK → IDLE when a transfer makes `beats`==MAX_BURST, or when the owner's `req_valid` is low in any LOCK cycle. That low-valid cycle is a no-grant bubble.
  - On release, `rr_ptr` ← owner+1.
  - A full FIFO holds LOCK indefinitely.
- **Undefined:** no FSM, `owner` or `beats` registers. Per-beat round-robin as above; `MAX_BURST` is ignored.

## Structure
- Shared package `fifo_pkg`:
  - `arb_state_t` enum (IDLE, LOCK)
  - `XFER_CNT_W`=16
  - function `rr_pick(valid, ptr)` returning winner index and a found flag
- Sub-module `rr_priority_pick`: combinational rotate / priority-encode / un-rotate over `NUM_REQ` bits. Reusable by a later read-side scheduler.

## Test plan
- **Reset:** `rst_n`=0 with all `req_valid`=1 → `fifo_wr_en`=0, `req_ready`=0, `xfer_count`=0. Release reset → first grant goes to producer 0.
- **Round-robin, burst off:** 4 producers always valid, data 8'h10+i, 8 cycles → FIFO receives 10,11,12,13,10,11,12,13 and `xfer_count`=8.
- **Full back-pressure:** `fifo_full`=1 for 3 cycles mid-stream → `req_ready`=0 and `fifo_wr_en`=0, nothing lost. Resumes with the same producer that was pending.
- **Sparse requests:** only producers 1 and 3 valid, `rr_ptr`=2 → order 3,1,3,1. Grant with wrap is correct.
- **Burst on, MAX_BURST=4, all valid:** FIFO sequence 0,0,0,0,1,1,1,1,…
- **Burst early release and overflow count:**
  - Owner drops valid after 2 beats → one bubble cycle, then next producer.
  - Preload `xfer_count` near 0xFFFF via a long run → it saturates at 0xFFFF.
